// File: rtl/pkt_hdr_ins_p.sv
// rtl/pkt_hdr_ins_p.sv - packet header inserter: buffers packets, prefixes length and checksum words
module pkt_hdr_ins_p #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 256,
    parameter int MSG_DEPTH = 4,
    parameter int CKSUM_EN  = 1,
    parameter int LEN_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic              din_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    input  logic              dout_rdy,
    output logic              err_trunc
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int MW  = DATA_W + LEN_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HLEN,
        S_HSUM,
        S_DATA
    } state_t;

    // data buffer: {eop, data}; pointers wrap naturally because DEPTH is a power of 2
    logic [DATA_W:0]   dmem [DEPTH];
    logic [AW-1:0]     dwr_ptr;
    logic [AW-1:0]     drd_ptr;
    logic [AW:0]       dcnt;

    // header-info buffer: {checksum, length} per packet
    logic [MW-1:0]     mmem [MSG_DEPTH];
    logic [MAW-1:0]    mwr_ptr;
    logic [MAW-1:0]    mrd_ptr;
    logic [MAW:0]      mcnt;

    // input-side packet accumulation
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] acc;
    logic              discard;

    state_t            state;

    logic              data_full;
    logic              msg_full;
    logic              accept;
    logic              store;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] folded;
    logic [LEN_W-1:0]  next_len;
    logic              at_limit;
    logic              last;
    logic              trunc;
    logic              msg_wr;
    logic              load;
    logic              data_rd;
    logic              msg_pop;
    logic [DATA_W:0]   drd_word;
    logic [LEN_W-1:0]  msg_len;
    logic [DATA_W-1:0] msg_ck;
    logic [DATA_W-1:0] len_ext;
    logic              unused_sop;

    // sop is informational only; packet boundaries come from eop
    assign unused_sop = din_sop;

    assign data_full = (dcnt == (AW+1)'(DEPTH));
    assign msg_full  = (mcnt == (MAW+1)'(MSG_DEPTH));

    // while discarding the tail of a truncated packet, everything is swallowed
    assign din_rdy  = !rst && (discard || (!data_full && !msg_full));
    assign accept   = din_vld && din_rdy;
    assign store    = accept && !discard;

    // one's-complement running sum with end-around carry
    assign sum      = {1'b0, acc} + {1'b0, din};
    assign folded   = sum[DATA_W-1:0] + DATA_W'(sum[DATA_W]);

    assign next_len = count + LEN_W'(1);
    assign at_limit = (next_len == LEN_W'(DEPTH));
    assign last     = din_eop || at_limit;
    assign trunc    = at_limit && !din_eop;
    assign msg_wr   = store && last;

    // output register may take a new word when empty or being drained
    assign load     = !dout_vld || dout_rdy;
    assign drd_word = dmem[drd_ptr];
    assign data_rd  = load && (state == S_DATA);
    assign msg_pop  = data_rd && drd_word[DATA_W];

    assign msg_len  = mmem[mrd_ptr][LEN_W-1:0];
    assign msg_ck   = mmem[mrd_ptr][MW-1:LEN_W];

    // zero-extend the length field to a full data word
    always_comb begin
        len_ext              = '0;
        len_ext[LEN_W-1:0]   = msg_len;
    end

    // data buffer storage; eop is forced on the word that hits the length limit
    always_ff @(posedge clk) begin
        if (store) begin
            dmem[dwr_ptr] <= {last, din};
        end
    end

    // header-info storage: inverted folded sum and word count of the finished packet
    always_ff @(posedge clk) begin
        if (msg_wr) begin
            mmem[mwr_ptr] <= {~folded, next_len};
        end
    end

    // input side: write pointers, word count, checksum accumulator, truncation/discard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwr_ptr   <= '0;
            mwr_ptr   <= '0;
            count     <= '0;
            acc       <= '0;
            discard   <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= store && trunc;
            if (store) begin
                dwr_ptr <= dwr_ptr + AW'(1);
                if (last) begin
                    count   <= '0;
                    acc     <= '0;
                    mwr_ptr <= mwr_ptr + MAW'(1);
                end else begin
                    count   <= next_len;
                    acc     <= folded;
                end
            end
            if (store && trunc) begin
                discard <= 1'b1;
            end else if (accept && discard && din_eop) begin
                discard <= 1'b0;
            end
        end
    end

    // read side pointers advance as data words and finished headers leave
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drd_ptr <= '0;
            mrd_ptr <= '0;
        end else begin
            if (data_rd) begin
                drd_ptr <= drd_ptr + AW'(1);
            end
            if (msg_pop) begin
                mrd_ptr <= mrd_ptr + MAW'(1);
            end
        end
    end

    // occupancy counters; simultaneous write and read leaves them unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= '0;
            mcnt <= '0;
        end else begin
            case ({store, data_rd})
                2'b10:   dcnt <= dcnt + (AW+1)'(1);
                2'b01:   dcnt <= dcnt - (AW+1)'(1);
                default: dcnt <= dcnt;
            endcase
            case ({msg_wr, msg_pop})
                2'b10:   mcnt <= mcnt + (MAW+1)'(1);
                2'b01:   mcnt <= mcnt - (MAW+1)'(1);
                default: mcnt <= mcnt;
            endcase
        end
    end

    // output FSM: state names the next word to load into the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        dout_vld <= 1'b0;
                        dout_sop <= 1'b0;
                        dout_eop <= 1'b0;
                    end
                    if (mcnt != '0) begin
                        state <= S_HLEN;
                    end
                end
                S_HLEN: begin
                    if (load) begin
                        dout     <= len_ext;
                        dout_vld <= 1'b1;
                        dout_sop <= 1'b1;
                        dout_eop <= 1'b0;
                        state    <= (CKSUM_EN != 0) ? S_HSUM : S_DATA;
                    end
                end
                S_HSUM: begin
                    if (load) begin
                        dout     <= msg_ck;
                        dout_vld <= 1'b1;
                        dout_sop <= 1'b0;
                        dout_eop <= 1'b0;
                        state    <= S_DATA;
                    end
                end
                default: begin
                    if (load) begin
                        dout     <= drd_word[DATA_W-1:0];
                        dout_vld <= 1'b1;
                        dout_sop <= 1'b0;
                        dout_eop <= drd_word[DATA_W];
                        if (drd_word[DATA_W]) begin
                            // a header still queued (or arriving now) follows with no bubble
                            state <= ((mcnt > (MAW+1)'(1)) || msg_wr) ? S_HLEN : S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_hdr_ins_p.sv
// tb/tb_pkt_hdr_ins_p.sv - self-checking bench for pkt_hdr_ins_p
module tb_pkt_hdr_ins_p;

    localparam int DW  = 16;
    localparam int DEP = 8;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } ow_t;

    typedef struct packed {
        logic [3:0]        n;
        logic [11:0][15:0] w;
        logic [15:0]       len;
        logic [15:0]       ck;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_vld, din_sop, din_eop, din_rdy;
    logic [DW-1:0] dout;
    logic          dout_vld, dout_sop, dout_eop;
    logic          dout_rdy = 1'b0;
    logic          err_trunc;

    logic [DW-1:0] b_din;
    logic          b_din_vld, b_din_sop, b_din_eop, b_din_rdy;
    logic [DW-1:0] b_dout;
    logic          b_dout_vld, b_dout_sop, b_dout_eop;
    logic          b_dout_rdy;
    logic          b_err_trunc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 1;
    int gap_en   = 0;
    int eop_cyc  = 0;
    int lat_cyc  = 0;
    int lat_arm  = 0;
    int trunc_seen = 0;
    int exp_trunc  = 0;

    ow_t         exp_q[$];
    logic [15:0] pkt[$];
    ow_t         prev;
    logic        stall_prev = 1'b0;
    vec_t        tbl [6];

    pkt_hdr_ins_p #(.DATA_W(DW), .DEPTH(DEP), .MSG_DEPTH(4), .CKSUM_EN(1), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .din_rdy(din_rdy), .dout(dout), .dout_vld(dout_vld),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_rdy(dout_rdy), .err_trunc(err_trunc)
    );

    pkt_hdr_ins_p #(.DATA_W(DW), .DEPTH(DEP), .MSG_DEPTH(4), .CKSUM_EN(0), .LEN_W(4)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .din_vld(b_din_vld), .din_sop(b_din_sop),
        .din_eop(b_din_eop), .din_rdy(b_din_rdy), .dout(b_dout), .dout_vld(b_dout_vld),
        .dout_sop(b_dout_sop), .dout_eop(b_dout_eop), .dout_rdy(b_dout_rdy), .err_trunc(b_err_trunc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) dout_rdy = 1'($urandom_range(0, 1));
        else               dout_rdy = (rdy_mode == 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {13'd0, dout_vld, dout, dout_sop, dout_eop}, {13'd0, 1'b1, prev});
            if (dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none", dout);
                end else begin
                    ow_t e;
                    e = exp_q.pop_front();
                    check("out_word", {13'd0, dout, dout_sop, dout_eop}, {13'd0, e});
                end
            end
            stall_prev = dout_vld && !dout_rdy;
            prev       = {dout, dout_sop, dout_eop};
            if (err_trunc) trunc_seen++;
            if (lat_arm != 0 && dout_vld) begin
                lat_cyc = cyc;
                lat_arm = 0;
            end
        end
    end

    task automatic send_pkt(input int no_eop);
        bit ok;
        for (int i = 0; i < pkt.size(); i++) begin
            din     = pkt[i];
            din_vld = 1'b1;
            din_sop = (i == 0);
            din_eop = (i == pkt.size() - 1) && (no_eop == 0);
            ok = 1'b0;
            for (int t = 0; t < 300 && !ok; t++) begin
                @(negedge clk);
                ok = din_rdy;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL din_accept_timeout actual=0 required=1");
            end
            if (din_eop) eop_cyc = cyc;
            din_vld = 1'b0;
            din_sop = 1'b0;
            din_eop = 1'b0;
            if (gap_en != 0 && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // reference: header = kept word count and inverted one's-complement sum of kept words
    task automatic push_model();
        int kept;
        int s;
        kept = (pkt.size() > DEP) ? DEP : pkt.size();
        s = 0;
        for (int i = 0; i < kept; i++) s += int'(pkt[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        exp_q.push_back({16'(kept), 1'b1, 1'b0});
        exp_q.push_back({~16'(s), 1'b0, 1'b0});
        for (int i = 0; i < kept; i++) exp_q.push_back({pkt[i], 1'b0, i == kept - 1});
        if (pkt.size() > DEP) exp_trunc++;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        check("drain_remaining", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        ow_t bw [4];
        int  got;
        int  eop0;
        bit  ok;

        tbl[0] = '{n: 4'd3,  w: {144'h0, 16'h3, 16'h2, 16'h1}, len: 16'h3, ck: 16'hFFF9};
        tbl[1] = '{n: 4'd2,  w: {160'h0, 16'h2, 16'hFFFF},     len: 16'h2, ck: 16'hFFFD};
        tbl[2] = '{n: 4'd1,  w: {176'h0, 16'h1234},            len: 16'h1, ck: 16'hEDCB};
        tbl[3] = '{n: 4'd10, w: {32'h0, 16'hA, 16'h9, 16'h8, 16'h7, 16'h6, 16'h5, 16'h4,
                                 16'h3, 16'h2, 16'h1},          len: 16'h8, ck: 16'hFFDB};
        tbl[4] = '{n: 4'd8,  w: {64'h0, 16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2,
                                 16'h1},                        len: 16'h8, ck: 16'hFFDB};
        tbl[5] = '{n: 4'd2,  w: {160'h0, 16'h8000, 16'h8000},  len: 16'h2, ck: 16'hFFFE};

        rst = 1'b1;
        din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        b_din = '0; b_din_vld = 1'b0; b_din_sop = 1'b0; b_din_eop = 1'b0; b_dout_rdy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {din_rdy, dout_vld, dout_sop, dout_eop, err_trunc, dout}, 0);
        rst = 1'b0;
        #1;
        check("rdy_after_reset", din_rdy, 1);

        // directed table, dout_rdy held high
        lat_arm = 1;
        eop0 = 0;
        for (int k = 0; k < 6; k++) begin
            pkt.delete();
            for (int i = 0; i < tbl[k].n; i++) pkt.push_back(tbl[k].w[i]);
            exp_q.push_back({tbl[k].len, 1'b1, 1'b0});
            exp_q.push_back({tbl[k].ck, 1'b0, 1'b0});
            for (int i = 0; i < tbl[k].len; i++)
                exp_q.push_back({tbl[k].w[i], 1'b0, i == tbl[k].len - 1});
            send_pkt(0);
            if (k == 0) eop0 = eop_cyc;
        end
        wait_drain();
        check("hdr_latency", lat_cyc - eop0, 2);
        check("trunc_pulses_table", trunc_seen, 1);
        exp_trunc = 1;

        // header buffer fills while output is stalled
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            pkt.delete();
            pkt.push_back(16'h0010 + 16'(k));
            push_model();
            send_pkt(0);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("msg_full_rdy_low", din_rdy, 0);
        rdy_mode = 1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = din_rdy;
        end
        check("rdy_after_drain", ok, 1);
        @(posedge clk);
        #1;
        wait_drain();

        // randomized packets with random backpressure and input gaps
        rdy_mode = 2;
        gap_en   = 1;
        for (int k = 0; k < 40; k++) begin
            pkt.delete();
            for (int i = 0, n = $urandom_range(1, 11); i < n; i++) pkt.push_back(16'($urandom));
            push_model();
            send_pkt(0);
        end
        wait_drain();
        rdy_mode = 1;
        gap_en   = 0;
        check("trunc_pulses_total", trunc_seen, exp_trunc);

        // reset with one packet stalled in output and another half received
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        pkt.delete();
        pkt.push_back(16'h0101);
        pkt.push_back(16'h0202);
        send_pkt(0);
        pkt.delete();
        pkt.push_back(16'h0011);
        pkt.push_back(16'h0022);
        pkt.push_back(16'h0033);
        send_pkt(1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_vld", dout_vld, 1);
        rst = 1'b1;
        #1;
        check("midop_reset_outputs", {din_rdy, dout_vld, dout_sop, dout_eop, err_trunc, dout}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        exp_q.push_back({16'h0002, 1'b1, 1'b0});
        exp_q.push_back({16'hFEDB, 1'b0, 1'b0});
        exp_q.push_back({16'h4000, 1'b0, 1'b0});
        exp_q.push_back({16'hC123, 1'b0, 1'b1});
        pkt.delete();
        pkt.push_back(16'h4000);
        pkt.push_back(16'hC123);
        @(posedge clk);
        #1;
        send_pkt(0);
        wait_drain();
        check("trunc_after_reset", trunc_seen, exp_trunc);

        // length-only header variant
        got = 0;
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    b_din     = (i == 0) ? 16'hAAAA : 16'h5555;
                    b_din_vld = 1'b1;
                    b_din_sop = (i == 0);
                    b_din_eop = (i == 1);
                    ok = 1'b0;
                    for (int t = 0; t < 50 && !ok; t++) begin
                        @(negedge clk);
                        ok = b_din_rdy;
                        @(posedge clk);
                        #1;
                    end
                    b_din_vld = 1'b0;
                    b_din_sop = 1'b0;
                    b_din_eop = 1'b0;
                end
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    @(negedge clk);
                    if (b_dout_vld) begin
                        if (got < 4) bw[got] = {b_dout, b_dout_sop, b_dout_eop};
                        got++;
                    end
                end
            end
        join
        check("nock_word_count", got, 3);
        check("nock_len", {13'd0, bw[0]}, {13'd0, 16'h0002, 1'b1, 1'b0});
        check("nock_d0", {13'd0, bw[1]}, {13'd0, 16'hAAAA, 1'b0, 1'b0});
        check("nock_d1", {13'd0, bw[2]}, {13'd0, 16'h5555, 1'b0, 1'b1});
        check("nock_no_trunc", b_err_trunc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
